rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// Byte-stream boot loader: fills program/exception ROM, holds CPU in reset.
// Optional macro ROM_LOADER_READBACK_EN adds a CHECK cycle after each write.
module rom_loader #(
    parameter int WORDS = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        rom_we,
    output logic        rom_select,
    output logic [5:0]  rom_addr,
    output logic [31:0] rom_wd,
    input  logic [31:0] rom_rd,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [6:0]  words_loaded
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_BYTES = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
`ifdef ROM_LOADER_READBACK_EN
    localparam logic [2:0] S_CHECK = 3'd4;
`endif
    localparam logic [2:0] S_DONE  = 3'd5;

    // Largest legal word count, sized to match the count byte.
    localparam logic [7:0] LP_MAX = 8'(WORDS);

    logic [2:0]  r_state;
    logic        r_sel;
    logic [5:0]  r_addr;
    logic [31:0] r_wd;
    logic        r_cpu_rst;
    logic        r_busy;
    logic        r_err;
    logic [6:0]  r_words;
    logic [6:0]  r_count;
    logic [1:0]  r_bcnt;

    logic        w_ready;
    logic        w_hdr_ok;
    logic        w_cnt_ok;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_COUNT) ||
                      (r_state == S_BYTES);
    assign w_hdr_ok = (in_data[7:1] == 7'b1010000);
    assign w_cnt_ok = (in_data != 8'd0) && (in_data <= LP_MAX);

`ifdef ROM_LOADER_READBACK_EN
    logic w_rd_bad;
    assign w_rd_bad = (rom_rd != r_wd);
`else
    logic w_last_wr;
    logic w_unused_rd;
    assign w_last_wr   = ((r_words + 7'd1) == r_count);
    assign w_unused_rd = ^rom_rd;
`endif

    // Frame sequencer: header, count, 4-byte words, write, finish.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_sel     <= 1'b0;
            r_addr    <= 6'd0;
            r_wd      <= 32'd0;
            r_cpu_rst <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_words   <= 7'd0;
            r_count   <= 7'd0;
            r_bcnt    <= 2'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_hdr_ok) begin
                            r_state   <= S_COUNT;
                            r_sel     <= in_data[0];
                            r_busy    <= 1'b1;
                            r_cpu_rst <= 1'b1;
                            r_err     <= 1'b0;
                            r_words   <= 7'd0;
                            r_addr    <= 6'd0;
                            r_bcnt    <= 2'd0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_COUNT: begin
                    if (in_valid) begin
                        if (w_cnt_ok) begin
                            r_count <= in_data[6:0];
                            r_state <= S_BYTES;
                        end else begin
                            r_err     <= 1'b1;
                            r_busy    <= 1'b0;
                            r_cpu_rst <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                S_BYTES: begin
                    if (in_valid) begin
                        r_wd   <= {in_data, r_wd[31:8]};
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_words <= r_words + 7'd1;
`ifdef ROM_LOADER_READBACK_EN
                    r_state <= S_CHECK;
`else
                    if (w_last_wr) begin
                        r_state <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + 6'd1;
                        r_state <= S_BYTES;
                    end
`endif
                end
`ifdef ROM_LOADER_READBACK_EN
                S_CHECK: begin
                    if (w_rd_bad) begin
                        r_err <= 1'b1;
                    end
                    if (r_words == r_count) begin
                        r_state <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + 6'd1;
                        r_state <= S_BYTES;
                    end
                end
`endif
                S_DONE: begin
                    r_busy    <= 1'b0;
                    r_cpu_rst <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = w_ready;
    assign rom_we       = (r_state == S_WRITE);
    assign rom_select   = r_sel;
    assign rom_addr     = r_addr;
    assign rom_wd       = r_wd;
    assign cpu_rst      = r_cpu_rst;
    assign busy         = r_busy;
    assign done         = (r_state == S_DONE) && !r_err;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule
